// File: rtl/game_turn_ctrl.sv
// Turn sequencer for the board-game datapath: player-count setup, key pick,
// hit/miss evaluation, move and win check, with rotation, timeout and abort.
module game_turn_ctrl #(
    parameter int MAX_PLAYERS  = 4,
    parameter int MIN_PLAYERS  = 2,
    parameter int KEY_W        = 4,
    parameter int TURN_TIMEOUT = 1000,
    parameter int PW           = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             res_valid_i,
    input  logic             go_i,
    input  logic             win_valid_i,
    input  logic             win_i,
    output logic             setup_wr_o,
    output logic             pick_req_o,
    output logic [KEY_W-1:0] pick_o,
    output logic             pick_stb_o,
    output logic             move_en_o,
    output logic [PW:0]      n_players_o,
    output logic [PW-1:0]    cur_player_o,
    output logic [PW-1:0]    winner_o,
    output logic             timeout_o,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SELECT   = 4'd1,
        INIT     = 4'd2,
        WAIT_KEY = 4'd3,
        EVAL     = 4'd4,
        MISS     = 4'd5,
        MOVE     = 4'd6,
        CHECK    = 4'd7,
        DONE     = 4'd8
    } state_t;

    localparam int CW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TURN_TIMEOUT == 0) ? '0 : CW'(TURN_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             setup_wr_q, setup_wr_d;
    logic             pick_req_q, pick_req_d;
    logic [KEY_W-1:0] pick_q, pick_d;
    logic             pick_stb_q, pick_stb_d;
    logic             move_en_q, move_en_d;
    logic [PW:0]      n_players_q, n_players_d;
    logic [PW-1:0]    cur_q, cur_d;
    logic [PW-1:0]    winner_q, winner_d;
    logic             timeout_q, timeout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic key_ok;
    assign key_ok = (key_i >= KEY_W'(MIN_PLAYERS)) && (key_i <= KEY_W'(MAX_PLAYERS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            setup_wr_q  <= 1'b1;
            pick_req_q  <= 1'b0;
            pick_q      <= '0;
            pick_stb_q  <= 1'b0;
            move_en_q   <= 1'b0;
            n_players_q <= '0;
            cur_q       <= '0;
            winner_q    <= '0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            setup_wr_q  <= setup_wr_d;
            pick_req_q  <= pick_req_d;
            pick_q      <= pick_d;
            pick_stb_q  <= pick_stb_d;
            move_en_q   <= move_en_d;
            n_players_q <= n_players_d;
            cur_q       <= cur_d;
            winner_q    <= winner_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        setup_wr_d  = setup_wr_q;
        pick_d      = pick_q;
        pick_stb_d  = 1'b0;
        n_players_d = n_players_q;
        cur_d       = cur_q;
        winner_d    = winner_q;
        timeout_d   = 1'b0;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                setup_wr_d = 1'b1;
                if (start_i) state_d = SELECT;
            end
            SELECT: begin
                if (key_ok) begin
                    n_players_d = (PW+1)'(key_i);
                    state_d     = INIT;
                end
            end
            INIT: begin
                setup_wr_d = 1'b0;
                cur_d      = '0;
                cnt_d      = '0;
                winner_d   = '0;
                state_d    = WAIT_KEY;
            end
            WAIT_KEY: begin
                // A key arriving on the last allowed cycle beats the timeout.
                if (key_i != '0) begin
                    pick_d     = key_i;
                    pick_stb_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = EVAL;
                end else if (TURN_TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = MISS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EVAL: begin
                if (res_valid_i) state_d = go_i ? MOVE : MISS;
            end
            MISS: begin
                cur_d   = ({1'b0, cur_q} == n_players_q - 1'b1) ? '0 : cur_q + 1'b1;
                cnt_d   = '0;
                state_d = WAIT_KEY;
            end
            MOVE: state_d = CHECK;
            CHECK: begin
                if (win_valid_i) begin
                    if (win_i) begin
                        winner_d = cur_q;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_KEY;
                    end
                end
            end
            DONE: begin
                if (start_i) begin
                    setup_wr_d = 1'b1;
                    state_d    = SELECT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_i) begin
            state_d     = IDLE;
            setup_wr_d  = 1'b1;
            pick_stb_d  = 1'b0;
            timeout_d   = 1'b0;
            n_players_d = '0;
            cur_d       = '0;
            pick_d      = '0;
            cnt_d       = '0;
        end

        // Level outputs are registered from the next state so they line up with state_o.
        pick_req_d = (state_d == WAIT_KEY);
        move_en_d  = (state_d == MOVE);
    end

    assign setup_wr_o   = setup_wr_q;
    assign pick_req_o   = pick_req_q;
    assign pick_o       = pick_q;
    assign pick_stb_o   = pick_stb_q;
    assign move_en_o    = move_en_q;
    assign n_players_o  = n_players_q;
    assign cur_player_o = cur_q;
    assign winner_o     = winner_q;
    assign timeout_o    = timeout_q;
    assign state_o      = state_q;

endmodule

// File: doc/game_turn_ctrl.md
Name: game_turn_ctrl

Overview:
- Parametrised game-sequencing FSM for the board-game datapath; successor to the fixed 2–4-player control unit.
- Sequences setup (player count), per-turn key pick, hit/miss evaluation, piece move and win check.
- Adds player rotation, a per-turn timeout, explicit result handshakes, abort, winner reporting and restart.
- Sits between the keypad decoder and the board/position datapath.

Parameters:
- MAX_PLAYERS, 4, largest accepted player count (2..15).
- MIN_PLAYERS, 2, smallest accepted player count (>=1, <=MAX_PLAYERS).
- KEY_W, 4, keypad code width; code 0 = no key.
- TURN_TIMEOUT, 1000, cycles allowed in WAIT_KEY before a forced miss; 0 disables the timeout.
- PW, 2, player-index width; must satisfy 2^PW >= MAX_PLAYERS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- key  in  KEY_W  keypad code, 0 = idle
- start  in  1  level; start/restart request
- abort  in  1  level; return to IDLE from any state
- res_valid  in  1  hit/miss result valid (EVAL)
- go  in  1  1 = hit, 0 = miss; sampled with res_valid
- win_valid  in  1  win check valid (CHECK)
- win  in  1  1 = current player finished; sampled with win_valid
- setup_wr  out  1  board write enable during setup
- pick_req  out  1  high while waiting for a pick
- pick  out  KEY_W  latched pick code
- pick_stb  out  1  1-cycle pulse when pick is latched
- move_en  out  1  1-cycle move pulse
- n_players  out  PW+1  accepted player count
- cur_player  out  PW  active player, 0-based
- winner  out  PW  winning player, valid in DONE
- timeout  out  1  1-cycle pulse on turn timeout
- state  out  4  state code for debug/display

Behaviour:
- Reset: state=IDLE; setup_wr=1; all other outputs=0; timeout counter=0.
- All outputs are registered and change on the clk edge after the causing input sample.
- State codes: IDLE=0, SELECT=1, INIT=2, WAIT_KEY=3, EVAL=4, MISS=5, MOVE=6, CHECK=7, DONE=8.
- IDLE: setup_wr=1. If start=1, go to SELECT.
- SELECT: accept key only if MIN_PLAYERS <= key <= MAX_PLAYERS.
  - Accepted: n_players <= key, go to INIT.
  - Any other key, including 0: stay in SELECT.
- INIT: one cycle. setup_wr <= 0, cur_player <= 0, counter <= 0, go to WAIT_KEY.
- WAIT_KEY: pick_req=1; counter increments every cycle.
  - key != 0: pick <= key, pick_stb pulses, counter <= 0, go to EVAL.
  - Else, if TURN_TIMEOUT != 0 and counter == TURN_TIMEOUT-1: timeout pulses, go to MISS.
  - A key wins over timeout in the same cycle.
- EVAL: pick_req=0. Hold until res_valid=1, then go=1 goes to MOVE and go=0 goes to MISS.
- MISS: one cycle. cur_player <= (cur_player == n_players-1) ? 0 : cur_player+1, counter <= 0, go to WAIT_KEY.
- MOVE: move_en=1 for exactly this one cycle, then go to CHECK.
- CHECK: hold until win_valid=1.
  - win=1: winner <= cur_player, go to DONE.
  - win=0: same player keeps the turn, counter <= 0, go to WAIT_KEY.
- DONE: hold winner. start=1 goes to SELECT; setup_wr <= 1 and winner is kept until INIT.
- abort=1 in any state: next state IDLE, setup_wr <= 1, pulses suppressed, n_players/cur_player/pick cleared. abort has priority over every other input.
- rst has priority over abort.
- res_valid/win_valid outside EVAL/CHECK are ignored.
- key is level-sampled. Callers must deliver a single-cycle key pulse or release before the next WAIT_KEY; a held key re-picks on re-entry.

Test Plan:
- Setup: rst, start=1 1 cycle, key=5 then key=1 then key=3 → stays in SELECT for 5 and 1; n_players=3, state INIT→WAIT_KEY, setup_wr 1→0 at INIT.
- Rotation: n_players=3, three misses (key=7, res_valid+go=0) → cur_player 0→1→2→0; pick=7, pick_stb one cycle each turn.
- Hit and win: key=9, go=1, win_valid+win=0 → move_en one pulse, cur_player unchanged; repeat with win=1 → state=8, winner=cur_player; start → SELECT.
- Timeout: TURN_TIMEOUT=16, no key → timeout pulse exactly 16 cycles after WAIT_KEY entry, cur_player increments; key in cycle 16 → EVAL, no timeout pulse.
- Abort/reset mid-game: abort in EVAL with res_valid=1 → IDLE next cycle, no move_en, outputs cleared; rst and abort together → reset values.
- Parameter sweep: MAX_PLAYERS=8, PW=3, key=8 → accepted, cur_player wraps 7→0.
